shift_add_multiplier: RTL

- Sequential unsigned shift-add multiplier. It is the multiplication counterpart of the team's shift-subtract divider and uses the same Run/Ready handshake style.
- Control FSM, iteration counter and datapath (multiplicand register, combined product/multiplier register, (WIDTH+1)-bit adder) live in one block.
- Sits beside the divider under the ALU top level; one product per Run request.

---
 rtl/shift_add_multiplier.sv | 92 +++++++++
 1 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: one partial-product step per clock,
// WIDTH steps per product, Run/Ready handshake matching the shift-subtract divider.
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Ready,
    output logic                 Busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    mcand_q;
    logic [2*WIDTH-1:0]  prod_q;
    logic [CW-1:0]       cnt_q;
    logic                ready_q;
    logic                busy_q;
    logic [WIDTH:0]      sum_d;
    logic [2*WIDTH-1:0]  prod_d;

    // Handshake: Run is sampled only in IDLE and DONE. A start in IDLE raises
    // Busy on the next edge; Ready rises WIDTH edges later and stays high (with
    // Product stable) until Run is seen low in DONE, which returns to IDLE.
    // Holding Run high through DONE never retriggers a new operation.

    // Carry out of the upper-half add lands in sum_d[WIDTH] and becomes the new MSB.
    always_comb begin
        sum_d  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d = {sum_d, prod_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Run) begin
                        mcand_q <= Multiplicand;
                        prod_q  <= {{WIDTH{1'b0}}, Multiplier};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!Run) begin
                        ready_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Product = prod_q;
    assign Ready   = ready_q;
    assign Busy    = busy_q;

endmodule
